// File: rtl/lfsr_prng_ctrl.sv
// Fibonacci LFSR pseudo-random generator with seed load, lock-up recovery,
// multi-slot state checkpoints and a handshaked burst-advance engine.
module lfsr_prng_ctrl #(
   parameter int              WIDTH      = 16,
   parameter logic [WIDTH-1:0] TAP_MASK  = 16'h002D,
   parameter logic [WIDTH-1:0] FILL      = 16'hACE1,
   parameter int              OUT_BITS   = 3,
   parameter int              SNAP_DEPTH = 4,
   parameter int              BURST_W    = 8,
   localparam int             SEL_W      = (SNAP_DEPTH > 1) ? $clog2(SNAP_DEPTH) : 1
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic                step_i,
   input  logic                randomize_i,
   input  logic                load_seed_i,
   input  logic [WIDTH-1:0]    seed_i,
   input  logic                save_i,
   input  logic                restore_i,
   input  logic [SEL_W-1:0]    slot_sel_i,
   input  logic                burst_start_i,
   input  logic [BURST_W-1:0]  burst_len_i,
   output logic                random_o,
   output logic [OUT_BITS-1:0] rand_bits_o,
   output logic [WIDTH-1:0]    state_o,
   output logic                busy_o,
   output logic                done_o,
   output logic                lockup_o
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] BURST = 1'b1;

   logic [WIDTH-1:0]   state_q, state_d;
   logic [WIDTH-1:0]   slot_q [SNAP_DEPTH];
   logic [0:0]         fsm_q, fsm_d;
   logic [BURST_W-1:0] cnt_q, cnt_d;
   logic               randomize_q;
   logic               done_q, done_d;
   logic               lockup_q, lockup_d;

   logic [WIDTH-1:0]   shifted;
   logic [WIDTH-1:0]   candidate;
   logic               updated;
   logic               randFall;

   assign shifted  = {^(state_q & TAP_MASK), state_q[WIDTH-1:1]};
   assign randFall = randomize_q & ~randomize_i;

   // Next-state selection in priority order; any all-zero result is swapped for FILL.
   always_comb begin
      candidate = state_q;
      updated   = 1'b0;
      fsm_d     = fsm_q;
      cnt_d     = cnt_q;
      done_d    = 1'b0;
      if (load_seed_i) begin
         candidate = seed_i;
         updated   = 1'b1;
         fsm_d     = IDLE;
      end else if (restore_i) begin
         candidate = slot_q[slot_sel_i];
         updated   = 1'b1;
         fsm_d     = IDLE;
      end else if (fsm_q == BURST) begin
         candidate = shifted;
         updated   = 1'b1;
         cnt_d     = cnt_q - 1'b1;
         if (cnt_q == BURST_W'(1)) begin
            fsm_d  = IDLE;
            done_d = 1'b1;
         end
      end else if (burst_start_i) begin
         if (burst_len_i == '0) begin
            done_d = 1'b1;
         end else begin
            cnt_d = burst_len_i;
            fsm_d = BURST;
         end
      end else if (step_i | randomize_i) begin
         candidate = shifted;
         updated   = 1'b1;
      end
      state_d  = candidate;
      lockup_d = 1'b0;
      if (updated && (candidate == '0)) begin
         state_d  = FILL;
         lockup_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= FILL;
         fsm_q       <= IDLE;
         cnt_q       <= '0;
         randomize_q <= 1'b0;
         done_q      <= 1'b0;
         lockup_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         fsm_q       <= fsm_d;
         cnt_q       <= cnt_d;
         randomize_q <= randomize_i;
         done_q      <= done_d;
         lockup_q    <= lockup_d;
      end
   end

   // Checkpoints always capture the pre-edge state; save and the randomize snapshot agree on slot 0.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < SNAP_DEPTH; i++) begin
            slot_q[i] <= FILL;
         end
      end else begin
         for (int i = 0; i < SNAP_DEPTH; i++) begin
            if ((save_i && (slot_sel_i == SEL_W'(i))) || ((i == 0) && randFall)) begin
               slot_q[i] <= state_q;
            end
         end
      end
   end

   assign random_o    = state_q[0];
   assign rand_bits_o = state_q[OUT_BITS:1];
   assign state_o     = state_q;
   assign busy_o      = (fsm_q == BURST);
   assign done_o      = done_q;
   assign lockup_o    = lockup_q;

endmodule
